// File: rtl/seg7_mmio.sv
// Eight-digit seven-segment display controller on the system bus.
// Holds a 32-bit display word and a control register, scans the digits
// one at a time onto a common-anode display, and answers bus reads with
// a one-cycle registered response.
module seg7_mmio #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        system_bus_en,
    input  logic        system_bus_rdwr,
    input  logic [3:0]  system_bus_mask,
    input  logic [31:0] system_bus_addr,
    input  logic [31:0] system_bus_wr_data,
    output logic [31:0] system_bus_rd_data,
    output logic        rd_valid,
    output logic [7:0]  an,
    output logic [6:0]  a_to_g
);

    localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    logic [1:0]       reg_sel;
    logic             wr_strobe;
    logic             rd_strobe;
    logic [31:0]      data_word;
    logic [8:0]       ctrl_reg;
    logic [DIV_W-1:0] div_cnt_reg;
    logic [2:0]       digit_idx_reg;
    logic [15:0]      frame_cnt_reg;
    logic [31:0]      rd_data_reg;
    logic             rd_valid_reg;
    logic [31:0]      rd_mux_next;
    logic [7:0]       an_reg;
    logic [6:0]       seg_reg;
    logic [3:0]       nibble_next;
    logic             lit_next;
    logic [6:0]       seg_next;
    logic             unused_addr_bits;

    assign reg_sel          = system_bus_addr[3:2];
    assign wr_strobe        = system_bus_en & system_bus_rdwr;
    assign rd_strobe        = system_bus_en & ~system_bus_rdwr;
    assign unused_addr_bits = ^{system_bus_addr[31:4], system_bus_addr[1:0]};

    // One independently write-enabled byte lane per slice of the display word.
    for (genvar gi = 0; gi < 4; gi++) begin : g_data_lane
        logic [7:0] lane_reg;

        // Byte lane gi of DATA, written only when its mask bit is set.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                lane_reg <= 8'h00;
            end else if (wr_strobe && reg_sel == 2'd0 && system_bus_mask[gi]) begin
                lane_reg <= system_bus_wr_data[8*gi +: 8];
            end
        end

        assign data_word[8*gi +: 8] = lane_reg;
    end

    // CTRL keeps only the digit enables and blank bit; upper bits do not exist.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_reg <= 9'h0FF;
        end else if (wr_strobe && reg_sel == 2'd1) begin
            if (system_bus_mask[0]) ctrl_reg[7:0] <= system_bus_wr_data[7:0];
            if (system_bus_mask[1]) ctrl_reg[8]   <= system_bus_wr_data[8];
        end
    end

    // Refresh divider, digit index and frame counter for the scan.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_reg   <= '0;
            digit_idx_reg <= 3'd0;
            frame_cnt_reg <= 16'h0000;
        end else if (div_cnt_reg == DIV_LAST) begin
            div_cnt_reg   <= '0;
            digit_idx_reg <= digit_idx_reg + 3'd1;
            if (digit_idx_reg == 3'd7) frame_cnt_reg <= frame_cnt_reg + 16'd1;
        end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
        end
    end

    // Read mux over the register map, sampled from pre-edge state.
    always_comb begin
        rd_mux_next = 32'h0000_0000;
        case (reg_sel)
            2'd0:    rd_mux_next = data_word;
            2'd1:    rd_mux_next = {23'h0, ctrl_reg};
            2'd2:    rd_mux_next = {frame_cnt_reg, 13'h0, digit_idx_reg};
            default: rd_mux_next = 32'h0000_0000;
        endcase
    end

    // Registered read response; data holds between reads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_reg  <= 32'h0000_0000;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= rd_strobe;
            if (rd_strobe) rd_data_reg <= rd_mux_next;
        end
    end

    // Current digit's nibble, lit decision and active-low hex decode.
    always_comb begin
        nibble_next = data_word[{digit_idx_reg, 2'b00} +: 4];
        lit_next    = ctrl_reg[digit_idx_reg] & ~ctrl_reg[8];
        seg_next    = 7'h7F;
        case (nibble_next)
            4'h0: seg_next = 7'h01;
            4'h1: seg_next = 7'h4F;
            4'h2: seg_next = 7'h12;
            4'h3: seg_next = 7'h06;
            4'h4: seg_next = 7'h4C;
            4'h5: seg_next = 7'h24;
            4'h6: seg_next = 7'h20;
            4'h7: seg_next = 7'h0F;
            4'h8: seg_next = 7'h00;
            4'h9: seg_next = 7'h04;
            4'hA: seg_next = 7'h08;
            4'hB: seg_next = 7'h60;
            4'hC: seg_next = 7'h31;
            4'hD: seg_next = 7'h42;
            4'hE: seg_next = 7'h30;
            default: seg_next = 7'h38;
        endcase
    end

    // Registered output stage, refreshed every cycle so writes show at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an_reg  <= 8'hFF;
            seg_reg <= 7'h7F;
        end else if (lit_next) begin
            an_reg  <= ~(8'h01 << digit_idx_reg);
            seg_reg <= seg_next;
        end else begin
            an_reg  <= 8'hFF;
            seg_reg <= 7'h7F;
        end
    end

    assign system_bus_rd_data = rd_data_reg;
    assign rd_valid           = rd_valid_reg;
    assign an                 = an_reg;
    assign a_to_g             = seg_reg;

endmodule
